// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths and arbiter state encoding for the register
//               file write-back path.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // The state names the requester granted most recently.
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter; one-hot grant, history inside.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  arb_state_t state_q;
  arb_state_t state_d;

  // Grant is masked by reset so nothing can transfer while it is held.
  always_comb begin
    grant   = 2'b00;
    state_d = state_q;
    if (!reset) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (state_q == LAST0) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    if (grant[0]) begin
      state_d = LAST0;
    end else if (grant[1]) begin
      state_d = LAST1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LAST1;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Arbitrates ALU/load write-backs onto one register-file write
//               port and tracks pending destination registers for hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req0_valid,
  input  logic [ADDR_W-1:0]              req0_reg,
  input  logic [DATA_W-1:0]              req0_data,
  output logic                           req0_ready,
  input  logic                           req1_valid,
  input  logic [ADDR_W-1:0]              req1_reg,
  input  logic [DATA_W-1:0]              req1_data,
  output logic                           req1_ready,
  input  logic                           issue_valid,
  input  logic [ADDR_W-1:0]              issue_reg,
  input  logic [ADDR_W-1:0]              rd_reg1,
  input  logic [ADDR_W-1:0]              rd_reg2,
  output logic                           rd_hazard,
  output logic                           wr_enable,
  output logic [ADDR_W-1:0]              wr_reg,
  output logic [DATA_W-1:0]              wr_data,
  output logic [regfile_pkg::NUM_REGS-1:0] busy_vec
);

  import regfile_pkg::*;

  logic [1:0]          grant;
  logic                xfer;
  logic [ADDR_W-1:0]   xfer_reg;
  logic [DATA_W-1:0]   xfer_data;

  logic                wr_enable_q, wr_enable_d;
  logic [ADDR_W-1:0]   wr_reg_q,    wr_reg_d;
  logic [DATA_W-1:0]   wr_data_q,   wr_data_d;
  logic [NUM_REGS-1:0] busy_q,      busy_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    xfer      = |grant;
    xfer_reg  = grant[1] ? req1_reg  : req0_reg;
    xfer_data = grant[1] ? req1_data : req0_data;
  end

  // Register 0 is hardwired: its write-backs are consumed but never enabled.
  always_comb begin
    wr_enable_d = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (xfer) begin
      wr_enable_d = (xfer_reg != '0);
      wr_reg_d    = xfer_reg;
      wr_data_d   = xfer_data;
    end
  end

  // Clear first, then set, so a newer producer issued this cycle stays pending.
  always_comb begin
    busy_d = busy_q;
    if (xfer && (xfer_reg != '0)) begin
      busy_d[xfer_reg] = 1'b0;
    end
    if (issue_valid && (issue_reg != '0)) begin
      busy_d[issue_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_enable_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      wr_enable_q <= wr_enable_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign rd_hazard = busy_q[rd_reg1] | busy_q[rd_reg2];
  assign wr_enable = wr_enable_q;
  assign wr_reg    = wr_reg_q;
  assign wr_data   = wr_data_q;
  assign busy_vec  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed and randomized checks of regfile_wb_arbiter against
//               a behavioural model of grants, write port and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, issue_valid;
  logic [4:0]  req0_reg, req1_reg, issue_reg, rd_reg1, rd_reg2;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, rd_hazard, wr_enable;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] busy_vec;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_reg    (req0_reg),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_reg    (req1_reg),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .rd_reg1     (rd_reg1),
    .rd_reg2     (rd_reg2),
    .rd_hazard   (rd_hazard),
    .wr_enable   (wr_enable),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .busy_vec    (busy_vec)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_last;
  logic [31:0] m_busy;
  logic        m_wen;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic        act_r0, act_r1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_busy  = '0;
    m_wen   = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
  endtask

  task automatic idle_inputs();
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    issue_valid = 1'b0;
    issue_reg   = '0;
    rd_reg1     = '0;
    rd_reg2     = '0;
  endtask

  // One clock cycle: check combinational outputs, clock, check registered outputs.
  task automatic step();
    logic       g0, g1;
    logic [4:0] r;
    logic [31:0] d;
    #1;
    g0 = req0_valid && (!req1_valid || m_last == 1);
    g1 = req1_valid && (!req0_valid || m_last == 0);
    act_r0 = req0_ready;
    act_r1 = req1_ready;
    check_eq("req0_ready", req0_ready, g0);
    check_eq("req1_ready", req1_ready, g1);
    check_eq("rd_hazard", rd_hazard, m_busy[rd_reg1] | m_busy[rd_reg2]);
    @(posedge clk);
    #1;
    if (g0 || g1) begin
      r = g0 ? req0_reg  : req1_reg;
      d = g0 ? req0_data : req1_data;
      m_wen   = (r != 0);
      m_wreg  = r;
      m_wdata = d;
      m_last  = g0 ? 0 : 1;
      if (r != 0) m_busy[r] = 1'b0;
    end else begin
      m_wen = 1'b0;
    end
    if (issue_valid && issue_reg != 0) m_busy[issue_reg] = 1'b1;
    m_busy[0] = 1'b0;
    check_eq("wr_enable", wr_enable, m_wen);
    check_eq("wr_reg", wr_reg, m_wreg);
    check_eq("wr_data", wr_data, m_wdata);
    check_eq("busy_vec", busy_vec, m_busy);
    if (g0) req0_valid = 1'b0;
    if (g1) req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    req0_reg = 5'd1; req0_data = 32'h1; req1_reg = 5'd2; req1_data = 32'h2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_eq("rst_ready0", req0_ready, 1'b0);
    check_eq("rst_ready1", req1_ready, 1'b0);
    check_eq("rst_wr_enable", wr_enable, 1'b0);
    check_eq("rst_wr_reg", wr_reg, 5'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_busy", busy_vec, 32'd0);
    check_eq("rst_hazard", rd_hazard, 1'b0);
    idle_inputs();
    reset = 1'b0;

    // Single requester write-back
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
    step();
    check_eq("single_ready", act_r0, 1'b1);
    check_eq("single_wr_reg", wr_reg, 5'd5);
    check_eq("single_wr_data", wr_data, 32'hDEADBEEF);
    step();
    check_eq("single_wen_drop", wr_enable, 1'b0);

    // Contention: grants alternate starting with requester 0
    reset = 1'b1; #1; reset = 1'b0; model_reset();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_reg = 5'd1; req0_data = $urandom;
      req1_valid = 1'b1; req1_reg = 5'd2; req1_data = $urandom;
      step();
      check_eq("rr_grant0", act_r0, (i % 2 == 0));
      check_eq("rr_wr_reg", wr_reg, (i % 2 == 0) ? 5'd1 : 5'd2);
    end
    idle_inputs();
    step();

    // Scoreboard set, hazard, and clear on write-back
    issue_valid = 1'b1; issue_reg = 5'd7;
    step();
    issue_valid = 1'b0; rd_reg1 = 5'd7;
    #1;
    check_eq("sb_hazard_set", rd_hazard, 1'b1);
    req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'hCAFE0007;
    step();
    check_eq("sb_wen", wr_enable, 1'b1);
    check_eq("sb_busy7", busy_vec[7], 1'b0);
    check_eq("sb_hazard_clr", rd_hazard, 1'b0);

    // Same-cycle set and clear: set wins; issue to register 0 ignored
    issue_valid = 1'b1; issue_reg = 5'd9;
    req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 32'h99;
    step();
    check_eq("setclr_busy9", busy_vec[9], 1'b1);
    issue_reg = 5'd0;
    step();
    check_eq("issue0_busy0", busy_vec[0], 1'b0);
    issue_valid = 1'b0;

    // Register 0 write-back is consumed without enabling the write port
    req0_valid = 1'b1; req0_reg = 5'd0; req0_data = 32'h12345678;
    step();
    check_eq("r0_ready", act_r0, 1'b1);
    check_eq("r0_wen", wr_enable, 1'b0);

    // Asynchronous reset mid-operation
    issue_valid = 1'b1; issue_reg = 5'd3;
    step();
    issue_reg = 5'd4;
    step();
    issue_valid = 1'b0;
    req1_valid = 1'b1; req1_reg = 5'd11; req1_data = 32'hABCD0011;
    step();
    check_eq("mid_wen_before", wr_enable, 1'b1);
    req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'h1111;
    req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 32'h2222;
    #2 reset = 1'b1;
    #1;
    check_eq("mid_wen", wr_enable, 1'b0);
    check_eq("mid_busy", busy_vec, 32'd0);
    check_eq("mid_ready0", req0_ready, 1'b0);
    check_eq("mid_ready1", req1_ready, 1'b0);
    #1 reset = 1'b0;
    model_reset();
    step();
    check_eq("mid_first_grant0", act_r0, 1'b1);

    // Randomized traffic
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1;
        req0_reg   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        req0_data  = $urandom;
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1'b1;
        req1_reg   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        req1_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_reg   = 5'($urandom_range(0, 15));
      rd_reg1     = 5'($urandom_range(0, 15));
      rd_reg2     = 5'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 Parameter: ADDR_W, 5, register index width (32 registers).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  reset; asynchronous and active-high.
REQ-005 Port: req0_valid / req0_reg / req0_data  input  1/ADDR_W/DATA_W  ALU write-back request.
REQ-006 Port: req0_ready  output  1  grant to requester 0 this cycle.
REQ-007 Port: req1_valid / req1_reg / req1_data  input  1/ADDR_W/DATA_W  load write-back request.
REQ-008 Port: req1_ready  output  1  grant to requester 1 this cycle.
REQ-009 Port: issue_valid / issue_reg  input  1/ADDR_W  decode marks a destination register as pending.
REQ-010 Port: rd_reg1 / rd_reg2  input  ADDR_W each  source registers of the instruction in decode.
REQ-011 Port: rd_hazard  output  1  a source register has a pending write.
REQ-012 Port: wr_enable / wr_reg / wr_data  output  1/ADDR_W/DATA_W  registered drive of the register-file write port.
REQ-013 Port: busy_vec  output  32  per-register pending-write scoreboard.

Function
REQ-014 A transfer on requester n SHALL occur in a cycle where reqn_valid and reqn_ready are both 1.
REQ-015 reqn_ready SHALL be combinational from the valids and the arbiter state, and SHALL never be 1 for both requesters in the same cycle.
REQ-016 A requester SHALL hold valid, reg and data stable until its transfer; the block need not tolerate withdrawal.
REQ-017 Arbiter state SHALL be one of LAST0 or LAST1, the requester most recently granted.
REQ-018 One requester valid: it SHALL be granted regardless of state.
REQ-019 Both requesters valid: the one not named by the state SHALL be granted (round-robin).
REQ-020 On a grant, the state SHALL move to LAST0 or LAST1 matching the grantee; with no grant, the state SHALL hold.
REQ-021 A transfer SHALL appear on wr_enable/wr_reg/wr_data exactly one cycle later, for one cycle.
REQ-022 A transfer targeting register 0 SHALL be accepted (ready asserted), but wr_enable SHALL stay 0 for it.
REQ-023 With no transfer, wr_enable SHALL be 0 next cycle; wr_reg/wr_data SHALL hold their last values.
REQ-024 issue_valid with issue_reg != 0 SHALL set busy_vec[issue_reg] at the next edge.
REQ-025 issue_reg = 0 SHALL have no effect; busy_vec[0] SHALL be constant 0.
REQ-026 A transfer to register r != 0 SHALL clear busy_vec[r] at the same edge that loads wr_* for it.
REQ-027 Set and clear of the same register in one cycle: set SHALL win (the newer producer is pending).
REQ-028 rd_hazard SHALL be combinational: busy_vec[rd_reg1] OR busy_vec[rd_reg2].
REQ-029 Set/clear on different registers in one cycle SHALL both take effect.

Reset
REQ-030 While reset is high, outputs SHALL be: wr_enable=0, wr_reg=0, wr_data=0, busy_vec=0, rd_hazard=0.
REQ-031 While reset is high, req0_ready and req1_ready SHALL be 0, and no transfer SHALL occur.
REQ-032 Reset SHALL set the arbiter state to LAST1, so requester 0 wins the first contention.
REQ-033 Reset asserted mid-operation SHALL discard a registered write not yet presented and clear all pending busy bits, with no partial write emitted.

Structure
REQ-034 DATA_W, ADDR_W, NUM_REGS=32 and the LAST0/LAST1 state encoding SHALL live in a shared package, regfile_pkg.
REQ-035 The two-way round-robin grant logic SHALL be a sub-module, rr_arbiter2 (valids in, one-hot grant out, state inside).
REQ-036 The scoreboard and write-port register SHALL stay in regfile_wb_arbiter.

Verification
REQ-037 Single requester: req0 {reg 5, data 0xDEADBEEF} valid one cycle -> req0_ready=1 that cycle; next cycle wr_enable=1, wr_reg=5, wr_data=0xDEADBEEF; the cycle after, wr_enable=0.
REQ-038 Contention, both valid for 4 cycles after reset (req0 reg 1, req1 reg 2, each reasserted after its transfer) -> grants alternate 0,1,0,1; wr_reg sequence is 1,2,1,2.
REQ-039 Scoreboard: issue reg 7; then rd_reg1=7 -> rd_hazard=1; after a req1 transfer to reg 7, busy_vec[7]=0 when wr_enable=1, and rd_hazard=0.
REQ-040 Same-cycle set/clear on reg 9 (issue 9 plus write-back to 9) -> busy_vec[9]=1 afterwards; issue to reg 0 -> busy_vec stays 0.
REQ-041 Register 0 write: req0 reg 0, data 0x12345678 -> req0_ready=1, and wr_enable stays 0.
REQ-042 Reset mid-operation: busy regs 3 and 4 set and a transfer just granted, then reset pulses asynchronously -> wr_enable=0 and busy_vec=0 immediately; next contention grants req0.
